// File: rtl/hall_pkg.sv
// Shared types and helpers for the Hall-sensor front end: sector type,
// code decoding and signed sector distance.
package hall_pkg;

    typedef logic [2:0] sector_t;

    localparam int         SECTORS     = 6;
    localparam logic [2:0] CODE_ILL_LO = 3'b000;
    localparam logic [2:0] CODE_ILL_HI = 3'b111;

    // Sector distances (cur - prev mod 6) that count as a single legal step.
    localparam sector_t DELTA_FWD = 3'd1;
    localparam sector_t DELTA_REV = 3'(SECTORS - 1);

    typedef struct packed {
        logic    legal;
        sector_t sector;
    } hall_dec_t;

    // Tracks what the previous accepted code was, so the next legal code
    // knows whether a direction/skip decision is meaningful.
    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_LEGAL = 2'd1,
        ST_FAULT = 2'd2
    } trk_state_e;

    function automatic hall_dec_t hall_decode(input logic [2:0] code);
        hall_dec_t d;
        d.legal  = 1'b1;
        d.sector = '0;
        case (code)
            3'b001:      d.sector = 3'd0;
            3'b011:      d.sector = 3'd1;
            3'b010:      d.sector = 3'd2;
            3'b110:      d.sector = 3'd3;
            3'b100:      d.sector = 3'd4;
            3'b101:      d.sector = 3'd5;
            CODE_ILL_LO: d.legal  = 1'b0;
            CODE_ILL_HI: d.legal  = 1'b0;
            default:     d.legal  = 1'b0;
        endcase
        return d;
    endfunction

    function automatic sector_t sector_delta(input sector_t prev, input sector_t cur);
        logic [3:0] diff;
        diff = {1'b0, cur} + 4'(SECTORS) - {1'b0, prev};
        if (diff >= 4'(SECTORS)) begin
            diff = diff - 4'(SECTORS);
        end
        return diff[2:0];
    endfunction

endpackage

// File: rtl/hall_commutator_if.sv
// Hall front-end signal bundle: raw sensors in, decoded rotor state out.
// master = sensor/consumer side, slave = the hall_commutator block.
interface hall_commutator_if #(
    parameter int PERIOD_W = 24
);
    import hall_pkg::*;

    logic [2:0]          HS;
    sector_t             sector;
    logic                sector_valid;
    logic                step;
    logic                dir;
    logic                hall_fault;
    logic                skip;
    logic                stall;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;

    modport master (
        output HS,
        input  sector, sector_valid, step, dir, hall_fault, skip, stall,
        input  period, period_valid
    );

    modport slave (
        input  HS,
        output sector, sector_valid, step, dir, hall_fault, skip, stall,
        output period, period_valid
    );

endinterface

// File: rtl/hall_filter.sv
// Two-flop synchroniser and stability filter for the three Hall inputs;
// emits the accepted code and a one-cycle pulse whenever it changes.
module hall_filter #(
    parameter int FILTER_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_hs,
    output logic [2:0] o_code,
    output logic       o_accept
);

    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [1:0]       r_sync_vld;
    logic [2:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_acc;
    logic             r_acc_none;
    logic             r_accept;

    // r_sync_vld keeps the cleared synchroniser contents from being counted
    // as real samples right after reset.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all stages sample the
        // pre-edge values; blocking writes would collapse the pipeline.
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_vld <= '0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_none <= 1'b1;
            r_accept   <= 1'b0;
        end else begin
            r_sync1    <= i_hs;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_accept   <= 1'b0;
            if (r_sync_vld[1]) begin
                if ((r_sync2 != r_cand) || (r_cnt == '0)) begin
                    r_cand <= r_sync2;
                    r_cnt  <= CNT_W'(1);
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                    if ((r_cnt == CNT_LAST) && (r_acc_none || (r_cand != r_acc))) begin
                        r_acc      <= r_cand;
                        r_acc_none <= 1'b0;
                        r_accept   <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_code   = r_acc;
    assign o_accept = r_accept;

endmodule

// File: rtl/hall_commutator.sv
// Hall-sensor front end: filtered code -> sector, direction, fault, skip, stall.
// Define HALL_PERIOD_EN to build the inter-step period measurement.
module hall_commutator
    import hall_pkg::*;
#(
    parameter int FILTER_LEN   = 16,
    parameter int STALL_CYCLES = 2700000,
    parameter int PERIOD_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    hall_commutator_if.slave bus
);

    localparam int                 STALL_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    logic [2:0] w_code;
    logic       w_accept;
    hall_dec_t  w_dec;
    sector_t    w_delta;

    trk_state_e r_state;
    trk_state_e w_state_nxt;

    sector_t r_sector;
    logic    r_sector_valid;
    logic    r_step;
    logic    r_dir;
    logic    r_hall_fault;
    logic    r_skip;

    logic    w_step;
    logic    w_skip;
    sector_t w_sector_nxt;
    logic    w_valid_nxt;
    logic    w_dir_nxt;
    logic    w_fault_nxt;

    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_cnt_nxt;
    logic               r_stall;

    hall_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .i_hs     (bus.HS),
        .o_code   (w_code),
        .o_accept (w_accept)
    );

    assign w_dec   = hall_decode(w_code);
    assign w_delta = sector_delta(r_sector, w_dec.sector);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_dec.legal ? ST_LEGAL : ST_FAULT;
        end
    end

    // Direction and skip are only judged when the previous accepted code was
    // legal; the first legal code after reset or a fault just establishes one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_step       = 1'b0;
        w_skip       = 1'b0;
        w_sector_nxt = r_sector;
        w_valid_nxt  = r_sector_valid;
        w_dir_nxt    = r_dir;
        w_fault_nxt  = r_hall_fault;
        if (w_accept) begin
            if (!w_dec.legal) begin
                w_fault_nxt = 1'b1;
                w_valid_nxt = 1'b0;
            end else begin
                w_step       = 1'b1;
                w_sector_nxt = w_dec.sector;
                w_valid_nxt  = 1'b1;
                w_fault_nxt  = 1'b0;
                if (r_state == ST_LEGAL) begin
                    if (w_delta == DELTA_FWD) begin
                        w_dir_nxt = 1'b1;
                    end else if (w_delta == DELTA_REV) begin
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_skip = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sector       <= '0;
            r_sector_valid <= 1'b0;
            r_step         <= 1'b0;
            r_dir          <= 1'b1;
            r_hall_fault   <= 1'b0;
            r_skip         <= 1'b0;
        end else begin
            r_sector       <= w_sector_nxt;
            r_sector_valid <= w_valid_nxt;
            r_step         <= w_step;
            r_dir          <= w_dir_nxt;
            r_hall_fault   <= w_fault_nxt;
            r_skip         <= w_skip;
        end
    end

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (r_stall_cnt != STALL_MAX) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
        end
    end

    // A step in the same cycle as the threshold wins, so stall stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (w_step) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            r_stall     <= (w_stall_cnt_nxt == STALL_MAX);
        end
    end

`ifdef HALL_PERIOD_EN
    logic [PERIOD_W-1:0] r_per_cnt;
    logic                r_ref_vld;
    logic [PERIOD_W-1:0] r_period;
    logic                r_period_valid;
    logic                w_ref_drop;

    // A fault or a stall makes the running count meaningless as a period.
    assign w_ref_drop = (w_accept && !w_dec.legal) || r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt      <= '0;
            r_ref_vld      <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_step) begin
                r_per_cnt <= PERIOD_W'(1);
                r_ref_vld <= 1'b1;
                if (r_ref_vld && !r_stall) begin
                    r_period       <= r_per_cnt;
                    r_period_valid <= 1'b1;
                end
            end else begin
                if (r_per_cnt != {PERIOD_W{1'b1}}) begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
                if (w_ref_drop) begin
                    r_ref_vld <= 1'b0;
                end
            end
        end
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
`else
    assign bus.period       = {PERIOD_W{1'b0}};
    assign bus.period_valid = 1'b0;
`endif

    assign bus.sector       = r_sector;
    assign bus.sector_valid = r_sector_valid;
    assign bus.step         = r_step;
    assign bus.dir          = r_dir;
    assign bus.hall_fault   = r_hall_fault;
    assign bus.skip         = r_skip;
    assign bus.stall        = r_stall;

endmodule

// File: tb/tb_hall_commutator.sv
// Scoreboard bench for hall_commutator: stimulus queues expected step events,
// a negedge monitor pops and compares them; level outputs are checked inline.
module tb_hall_commutator;
    import hall_pkg::*;

    localparam int FL    = 16;
    localparam int STALL = 1200;
    localparam int PW    = 10;
`ifdef HALL_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    typedef struct packed {
        sector_t       sector;
        logic          dir;
        logic          skip;
        logic          pv;
        logic [PW-1:0] period;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [PW-1:0] model_period = '0;

    always #5 clk = ~clk;

    hall_commutator_if #(.PERIOD_W(PW)) hif ();

    hall_commutator #(
        .FILTER_LEN   (FL),
        .STALL_CYCLES (STALL),
        .PERIOD_W     (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_sector"},       32'(hif.sector),       0);
        check({pfx, "_sector_valid"}, 32'(hif.sector_valid), 0);
        check({pfx, "_step"},         32'(hif.step),         0);
        check({pfx, "_dir"},          32'(hif.dir),          1);
        check({pfx, "_hall_fault"},   32'(hif.hall_fault),   0);
        check({pfx, "_skip"},         32'(hif.skip),         0);
        check({pfx, "_stall"},        32'(hif.stall),        0);
        check({pfx, "_period"},       32'(hif.period),       0);
        check({pfx, "_period_valid"}, 32'(hif.period_valid), 0);
    endtask

    task automatic expect_step(input int sec, input bit dir, input bit skip,
                               input bit pv, input int period);
        exp_t e;
        e.sector = sector_t'(sec);
        e.dir    = dir;
        e.skip   = skip;
        e.pv     = pv & PER_EN;
        e.period = PW'(period);
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] code, input int hold);
        hif.HS = code;
        repeat (hold) @(negedge clk);
    endtask

    // Monitor: every step pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            model_period = '0;
        end else if (hif.step) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_step: got step with sector=%0d, expected no step (t=%0t)",
                         hif.sector, $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.pv) model_period = mon_e.period;
                check("step_sector",       32'(hif.sector),       32'(mon_e.sector));
                check("step_sector_valid", 32'(hif.sector_valid), 1);
                check("step_hall_fault",   32'(hif.hall_fault),   0);
                check("step_dir",          32'(hif.dir),          32'(mon_e.dir));
                check("step_skip",         32'(hif.skip),         32'(mon_e.skip));
                check("step_period_valid", 32'(hif.period_valid), 32'(mon_e.pv));
                check("step_period",       32'(hif.period),       32'(model_period));
            end
        end else if (hif.skip || hif.period_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL stray_pulse: got skip=%0b period_valid=%0b, expected 0 without step (t=%0t)",
                     hif.skip, hif.period_valid, $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hif.HS = 3'b001;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // First acquisition: outputs register FL+3 edges after release.
        expect_step(0, 1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        repeat (FL + 2) @(negedge clk);
        check("acq_early_valid", 32'(hif.sector_valid), 0);
        @(negedge clk);
        check("acq_valid",  32'(hif.sector_valid), 1);
        check("acq_sector", 32'(hif.sector),       0);
        repeat (1000 - FL - 3) @(negedge clk);

        // Forward rotation, 1000 cycles per code.
        expect_step(1, 1'b1, 1'b0, 1'b1, 1000); drive(3'b011, 1000);
        expect_step(2, 1'b1, 1'b0, 1'b1, 1000); drive(3'b010, 1000);
        expect_step(3, 1'b1, 1'b0, 1'b1, 1000); drive(3'b110, 1000);
        expect_step(4, 1'b1, 1'b0, 1'b1, 1000); drive(3'b100, 1000);
        expect_step(5, 1'b1, 1'b0, 1'b1, 1000); drive(3'b101, 1000);

        // Reverse 101->100, then a 5-cycle glitch on HS[0] must be ignored.
        expect_step(4, 1'b0, 1'b0, 1'b1, 1000); drive(3'b100, 200);
        check("rev_dir", 32'(hif.dir), 0);
        drive(3'b101, 5);
        drive(3'b100, 895);
        check("glitch_sector", 32'(hif.sector), 4);
        check("glitch_dir",    32'(hif.dir),    0);

        // 1100-cycle interval saturates the 10-bit period counter.
        expect_step(3, 1'b0, 1'b0, 1'b1, 1023); drive(3'b110, 1000);

        // Illegal code: fault, sector holds, reference discarded.
        drive(3'b111, 50);
        check("fault_level",  32'(hif.hall_fault),   1);
        check("fault_valid",  32'(hif.sector_valid), 0);
        check("fault_sector", 32'(hif.sector),       3);
        expect_step(0, 1'b0, 1'b0, 1'b0, 0); drive(3'b001, 40);
        check("fault_clear", 32'(hif.hall_fault), 0);
        repeat (960) @(negedge clk);

        // Jump 0->3: skip, direction held.
        expect_step(3, 1'b0, 1'b1, 1'b1, 1000); drive(3'b110, FL + 3 + STALL - 1);
        check("stall_before", 32'(hif.stall), 0);
        @(negedge clk);
        check("stall_at", 32'(hif.stall), 1);
        repeat (50) @(negedge clk);
        check("stall_held", 32'(hif.stall), 1);

        // Step after stall clears it and only re-arms the period reference.
        expect_step(4, 1'b1, 1'b0, 1'b0, 0); drive(3'b100, 100);
        check("stall_clear", 32'(hif.stall), 0);
        expect_step(5, 1'b1, 1'b0, 1'b1, 100); drive(3'b101, 30);

        // Reset mid-rotation.
        rst = 1'b1;
        hif.HS = 3'b010;
        @(negedge clk);
        check_reset("midrst");
        check("midrst_queue", 32'(sb_q.size()), 0);
        expect_step(2, 1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        repeat (FL + 3) @(negedge clk);
        check("reacq_sector", 32'(hif.sector),       2);
        check("reacq_valid",  32'(hif.sector_valid), 1);
        repeat (10) @(negedge clk);
        check("final_queue", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
